grid_position_tracker: RTL and testbench
========================================

Name: grid_position_tracker

Overview:
- Consumer end of the 4-bit direction control word from the direction state machine.
- Generates a periodic step tick, decodes the direction word on each tick, and advances registered x (column) / y (row) grid positions with wrap-around or clamping.
- Sits between the direction controller and the display/collision logic; x_pos/y_pos drive the pixel renderer.

Parameters:
COLS, 16, number of grid columns; legal x range 0..COLS-1; COLS <= 2**X_W
ROWS, 12, number of grid rows; legal y range 0..ROWS-1; ROWS <= 2**Y_W
X_W, 4, width of x_pos
Y_W, 4, width of y_pos
STEP_DIV, 12500000, clk cycles per step tick (4 steps/s at 50 MHz); must be >= 1
X_INIT, 0, x_pos value after reset/restart
Y_INIT, 0, y_pos value after reset/restart
WRAP, 1, 1 = wrap to opposite edge at boundary; 0 = clamp (hold) at boundary

Ports:
clk  in  1  system clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
enable  in  1  1 = prescaler runs and steps occur; 0 = frozen
restart  in  1  synchronous reload of positions and prescaler
dir_ctrl  in  4  bit0 x count_enable, bit1 x updown (1 = increment), bit2 y count_enable, bit3 y updown (1 = increment)
x_pos  out  X_W  current column, registered
y_pos  out  Y_W  current row, registered
step_pulse  out  1  one-cycle pulse, high in the first cycle the post-step position is visible
edge_hit  out  1  one-cycle pulse, coincident with step_pulse, when the step hit a boundary
ctrl_err  out  1  one-cycle pulse, coincident with step_pulse, when dir_ctrl had both enables set

Behaviour:
- Reset (rstn low, async): x_pos=X_INIT, y_pos=Y_INIT, prescaler=0, step_pulse=0, edge_hit=0, ctrl_err=0.
- Prescaler: counts 0..STEP_DIV-1 while enable=1, wrapping to 0.
  - Step event is the cycle with prescaler==STEP_DIV-1 and enable=1.
  - With STEP_DIV=1, every enabled cycle is a step event.
- enable=0: prescaler holds its value (not cleared), no step events, positions hold, pulses 0.
- dir_ctrl is sampled combinationally in the step-event cycle. Positions and pulses update on that clock edge, so latency is 1 clk from step event to new position, with step_pulse high in that same cycle.
- Decode at step event:
  - bit0=1, bit2=0: x moves; +1 if bit1=1, else -1; y holds.
  - bit2=1, bit0=0: y moves; +1 if bit3=1, else -1; x holds.
  - bit0=0, bit2=0: no move; step_pulse still fires; edge_hit=0.
  - bit0=1, bit2=1: illegal; no move; ctrl_err=1 with step_pulse; edge_hit=0.
- Boundary, x (y identical with ROWS):
  - Increment from COLS-1: WRAP=1 gives 0; WRAP=0 holds COLS-1. edge_hit=1 in both modes.
  - Decrement from 0: WRAP=1 gives COLS-1; WRAP=0 holds 0. edge_hit=1 in both modes.
  - Boundary compare is against COLS-1, never 2**X_W-1. Positions never leave the legal range.
- restart=1 (sync): x_pos=X_INIT, y_pos=Y_INIT, prescaler=0, all pulses 0.
  - Overrides a coincident step event; that step is discarded.
  - Applies regardless of enable.
- Reset mid-step: async reset wins immediately. No pulse is emitted for the interrupted step.
- Pulses never stretch: each step event yields at most one cycle of step_pulse/edge_hit/ctrl_err.

Test Plan:
1. COLS=4, ROWS=3, STEP_DIV=4, WRAP=1; reset, dir_ctrl=0011 -> step_pulse every 4 clks; x_pos 0,1,2,3,0 with edge_hit only on the 3->0 step; y_pos stays 0.
2. Same config, dir_ctrl=0100 from y=0 -> y_pos 0->2 with edge_hit=1; next step 2->1 with edge_hit=0; x unchanged.
3. WRAP=0, x at 3, dir_ctrl=0011 -> x_pos stays 3 on each step, edge_hit=1 on each step; then dir_ctrl=0001 -> x_pos 2, edge_hit=0.
4. dir_ctrl=0101 at a step -> ctrl_err=1 and step_pulse=1 for exactly 1 clk; x/y unchanged. dir_ctrl=0000 -> step_pulse only, no movement.
5. Drop enable with prescaler=2 for 10 clks, then raise it -> no step while low; the next step occurs exactly 2 clks after enable rises (prescaler resumes at 2).
6. Assert restart in a step-event cycle with x=2 -> x_pos=X_INIT, no step_pulse; the next step occurs STEP_DIV clks later. Pulse rstn low mid-count -> outputs go to reset values immediately (async).

Source files
------------

// File: rtl/grid_position_tracker.sv
`default_nettype none
// grid_position_tracker: steps x/y grid position from a 4-bit direction word on a prescaled tick.
// Revision: 1.0

module grid_position_tracker #(
    parameter int COLS     = 16,
    parameter int ROWS     = 12,
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int STEP_DIV = 12500000,
    parameter int X_INIT   = 0,
    parameter int Y_INIT   = 0,
    parameter int WRAP     = 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           enable,
    input  logic           restart,
    input  logic [3:0]     dir_ctrl,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           step_pulse,
    output logic           edge_hit,
    output logic           ctrl_err
);

    localparam int             PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [X_W-1:0]  X_MAX   = X_W'(COLS - 1);
    localparam logic [Y_W-1:0]  Y_MAX   = Y_W'(ROWS - 1);
    localparam logic [X_W-1:0]  X_START = X_W'(X_INIT);
    localparam logic [Y_W-1:0]  Y_START = Y_W'(Y_INIT);
    localparam bit              DO_WRAP = (WRAP != 0);

    logic [PS_W-1:0] prescaler;
    logic            step_event;
    logic            x_move;
    logic            y_move;
    logic            illegal;
    logic [X_W-1:0]  x_next;
    logic [Y_W-1:0]  y_next;
    logic            x_edge;
    logic            y_edge;

    assign step_event = enable && (prescaler == PS_LAST);
    assign x_move     = dir_ctrl[0] && !dir_ctrl[2];
    assign y_move     = dir_ctrl[2] && !dir_ctrl[0];
    assign illegal    = dir_ctrl[0] && dir_ctrl[2];

    // Boundaries are the grid limits, not the register limits.
    always_comb begin
        x_next = x_pos;
        x_edge = 1'b0;
        if (x_move) begin
            if (dir_ctrl[1]) begin
                if (x_pos == X_MAX) begin
                    x_edge = 1'b1;
                    x_next = DO_WRAP ? '0 : X_MAX;
                end else begin
                    x_next = x_pos + X_W'(1);
                end
            end else begin
                if (x_pos == '0) begin
                    x_edge = 1'b1;
                    x_next = DO_WRAP ? X_MAX : '0;
                end else begin
                    x_next = x_pos - X_W'(1);
                end
            end
        end
    end

    always_comb begin
        y_next = y_pos;
        y_edge = 1'b0;
        if (y_move) begin
            if (dir_ctrl[3]) begin
                if (y_pos == Y_MAX) begin
                    y_edge = 1'b1;
                    y_next = DO_WRAP ? '0 : Y_MAX;
                end else begin
                    y_next = y_pos + Y_W'(1);
                end
            end else begin
                if (y_pos == '0) begin
                    y_edge = 1'b1;
                    y_next = DO_WRAP ? Y_MAX : '0;
                end else begin
                    y_next = y_pos - Y_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prescaler  <= '0;
            x_pos      <= X_START;
            y_pos      <= Y_START;
            step_pulse <= 1'b0;
            edge_hit   <= 1'b0;
            ctrl_err   <= 1'b0;
        end else if (restart) begin
            prescaler  <= '0;
            x_pos      <= X_START;
            y_pos      <= Y_START;
            step_pulse <= 1'b0;
            edge_hit   <= 1'b0;
            ctrl_err   <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            edge_hit   <= 1'b0;
            ctrl_err   <= 1'b0;
            if (enable) begin
                prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
            end
            if (step_event) begin
                x_pos      <= x_next;
                y_pos      <= y_next;
                step_pulse <= 1'b1;
                edge_hit   <= x_edge || y_edge;
                ctrl_err   <= illegal;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_grid_position_tracker.sv
`default_nettype none
// tb_grid_position_tracker: wrapping and clamping instances against a grid-rule model.
// Revision: 1.0

module tb_grid_position_tracker;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int DIV  = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] dir_ctrl = 4'b0000;

    logic [1:0] xw, xc;
    logic [1:0] yw, yc;
    logic       sw, sc, hw, hc, ew, ec;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    grid_position_tracker #(
        .COLS(COLS), .ROWS(ROWS), .X_W(2), .Y_W(2), .STEP_DIV(DIV),
        .X_INIT(0), .Y_INIT(0), .WRAP(1)
    ) dut_w (
        .clk(clk), .rstn(rstn), .enable(enable), .restart(restart), .dir_ctrl(dir_ctrl),
        .x_pos(xw), .y_pos(yw), .step_pulse(sw), .edge_hit(hw), .ctrl_err(ew)
    );

    grid_position_tracker #(
        .COLS(COLS), .ROWS(ROWS), .X_W(2), .Y_W(2), .STEP_DIV(DIV),
        .X_INIT(1), .Y_INIT(1), .WRAP(0)
    ) dut_c (
        .clk(clk), .rstn(rstn), .enable(enable), .restart(restart), .dir_ctrl(dir_ctrl),
        .x_pos(xc), .y_pos(yc), .step_pulse(sc), .edge_hit(hc), .ctrl_err(ec)
    );

    // Grid-rule reference: index 0 wraps, index 1 clamps.
    int pc;
    int ex[2];
    int ey[2];
    bit e_step, e_err;
    bit e_hit[2];

    function automatic int mv(int pos, bit en, bit up, int n, bit wrap);
        if (!en) return pos;
        if (up) return wrap ? (pos + 1) % n : ((pos + 1 > n - 1) ? n - 1 : pos + 1);
        return wrap ? (pos + n - 1) % n : ((pos - 1 < 0) ? 0 : pos - 1);
    endfunction

    function automatic bit hit(int pos, bit en, bit up, int n);
        return en && (up ? (pos == n - 1) : (pos == 0));
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn || restart) begin
            pc <= 0;
            ex[0] <= 0; ey[0] <= 0; ex[1] <= 1; ey[1] <= 1;
            e_step <= 1'b0; e_err <= 1'b0; e_hit[0] <= 1'b0; e_hit[1] <= 1'b0;
        end else begin
            e_step <= 1'b0; e_err <= 1'b0; e_hit[0] <= 1'b0; e_hit[1] <= 1'b0;
            if (enable) begin
                pc <= (pc + 1) % DIV;
                if (pc == DIV - 1) begin
                    e_step <= 1'b1;
                    e_err  <= dir_ctrl[0] && dir_ctrl[2];
                    ex[0] <= mv(ex[0], dir_ctrl[0] && !dir_ctrl[2], dir_ctrl[1], COLS, 1'b1);
                    ey[0] <= mv(ey[0], dir_ctrl[2] && !dir_ctrl[0], dir_ctrl[3], ROWS, 1'b1);
                    ex[1] <= mv(ex[1], dir_ctrl[0] && !dir_ctrl[2], dir_ctrl[1], COLS, 1'b0);
                    ey[1] <= mv(ey[1], dir_ctrl[2] && !dir_ctrl[0], dir_ctrl[3], ROWS, 1'b0);
                    e_hit[0] <= hit(ex[0], dir_ctrl[0] && !dir_ctrl[2], dir_ctrl[1], COLS) ||
                                hit(ey[0], dir_ctrl[2] && !dir_ctrl[0], dir_ctrl[3], ROWS);
                    e_hit[1] <= hit(ex[1], dir_ctrl[0] && !dir_ctrl[2], dir_ctrl[1], COLS) ||
                                hit(ey[1], dir_ctrl[2] && !dir_ctrl[0], dir_ctrl[3], ROWS);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("w.x", int'(xw), ex[0]);
            check("w.y", int'(yw), ey[0]);
            check("w.step", int'(sw), int'(e_step));
            check("w.edge", int'(hw), int'(e_hit[0]));
            check("w.err", int'(ew), int'(e_err));
            check("c.x", int'(xc), ex[1]);
            check("c.y", int'(yc), ey[1]);
            check("c.step", int'(sc), int'(e_step));
            check("c.edge", int'(hc), int'(e_hit[1]));
            check("c.err", int'(ec), int'(e_err));
        end
    end

    // Returns at the negedge where step_pulse is seen; n = negedges waited.
    task automatic next_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sw && n < 40);
        if (!sw) begin
            errors++;
            checks++;
            $display("FAIL step_timeout: got no step_pulse expected one within 40 cycles");
        end
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("reset w.x", int'(xw), 0);
        check("reset w.y", int'(yw), 0);
        check("reset c.x", int'(xc), 1);
        check("reset c.y", int'(yc), 1);
        check("reset step", int'(sw), 0);

        // Rightward sweep with wrap on the 3->0 step
        dir_ctrl = 4'b0011;
        enable = 1'b1;
        next_step(n);
        check("t1 first latency", n, 4);
        check("t1 x1", int'(xw), 1);
        check("t1 c x", int'(xc), 2);
        next_step(n);
        check("t1 spacing", n, 4);
        check("t1 x2", int'(xw), 2);
        check("t1 c x3", int'(xc), 3);
        next_step(n);
        check("t1 x3", int'(xw), 3);
        check("t1 edge none", int'(hw), 0);
        check("t1 c clamp", int'(xc), 3);
        check("t1 c clamp edge", int'(hc), 1);
        next_step(n);
        check("t1 wrap x", int'(xw), 0);
        check("t1 wrap edge", int'(hw), 1);
        check("t1 y still", int'(yw), 0);
        check("t1 c clamp again", int'(xc), 3);
        check("t1 c clamp edge2", int'(hc), 1);
        @(negedge clk);
        check("t1 pulse one cycle", int'(sw), 0);

        // Downward y: wrap 0->2, then 2->1
        dir_ctrl = 4'b0100;
        next_step(n);
        check("t2 y wrap", int'(yw), 2);
        check("t2 y wrap edge", int'(hw), 1);
        check("t2 c y", int'(yc), 0);
        next_step(n);
        check("t2 y dec", int'(yw), 1);
        check("t2 y dec edge", int'(hw), 0);
        check("t2 x held", int'(xw), 0);
        check("t2 c y clamp", int'(yc), 0);
        check("t2 c clamp edge", int'(hc), 1);

        // Clamped x steps back from 3
        dir_ctrl = 4'b0001;
        next_step(n);
        check("t3 c x dec", int'(xc), 2);
        check("t3 c edge", int'(hc), 0);

        // Illegal word, then no-move word
        dir_ctrl = 4'b0101;
        next_step(n);
        check("t4 err", int'(ew), 1);
        check("t4 edge", int'(hw), 0);
        check("t4 x hold", int'(xw), 3);
        @(negedge clk);
        check("t4 err one cycle", int'(ew), 0);
        dir_ctrl = 4'b0000;
        next_step(n);
        check("t4 idle step err", int'(ew), 0);
        check("t4 idle x", int'(xw), 3);

        // Freeze with prescaler at 2
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("t5 frozen no step", int'(sw), 0);
        end
        enable = 1'b1;
        next_step(n);
        check("t5 resume latency", n, 2);

        // Restart coincident with a step event
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        dir_ctrl = 4'b0011;
        next_step(n);
        next_step(n);
        check("t6 x at 2", int'(xw), 2);
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t6 restart x", int'(xw), 0);
        check("t6 restart no step", int'(sw), 0);
        check("t6 restart c x", int'(xc), 1);
        next_step(n);
        check("t6 post restart spacing", n, DIV);
        check("t6 x after", int'(xw), 1);

        // Async reset mid-cycle
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async w.x", int'(xw), 0);
        check("async c.x", int'(xc), 1);
        check("async step", int'(sw), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            dir_ctrl = 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 9) != 0);
            restart  = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
